// File: rtl/encoder4to2_seq_if.sv
// Request/handshake bundle for encoder4to2_seq: D0..D3 request strobes in,
// encoded index {A1,A0} out under a VALID/READY handshake.
interface encoder4to2_seq_if;
   logic       EN;
   logic       D0;
   logic       D1;
   logic       D2;
   logic       D3;
   logic       A0;
   logic       A1;
   logic       VALID;
   logic       READY;
   logic [2:0] PEND_CNT;
   logic       DROP;

   modport master (
      output EN, D0, D1, D2, D3, READY,
      input  A0, A1, VALID, PEND_CNT, DROP
   );

   modport slave (
      input  EN, D0, D1, D2, D3, READY,
      output A0, A1, VALID, PEND_CNT, DROP
   );
endinterface

// File: rtl/encoder4to2_seq.sv
// Sequential 4-to-2 request encoder: sticky pending bits, one index per transfer.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority D3 > D2 > D1 > D0.
module encoder4to2_seq (
   input  logic               clk,
   input  logic               rst_n,
   encoder4to2_seq_if.slave   bus
);
   typedef enum logic {IDLE, SHOW} state_t;

   state_t     state_q;
   logic [3:0] pending_q, pending_d;
   logic [3:0] req, clr;
   logic [1:0] code_q, sel;
   logic       valid_q, drop_q, drop_d, load;
`ifdef ROUND_ROBIN_EN
   logic [1:0] last_q;
   logic [1:0] idx;
   logic       found;
`endif

   always_comb begin
      req  = bus.EN ? {bus.D3, bus.D2, bus.D1, bus.D0} : '0;
      // IDLE loads whenever something is pending; SHOW only on a transfer.
      load = (|pending_q) && ((state_q == IDLE) || bus.READY);
      sel  = '0;
`ifdef ROUND_ROBIN_EN
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= 4; k++) begin
         idx = last_q - 2'(k);
         if (!found && pending_q[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
`else
      if (pending_q[3])      sel = 2'd3;
      else if (pending_q[2]) sel = 2'd2;
      else if (pending_q[1]) sel = 2'd1;
      else                   sel = 2'd0;
`endif
      clr       = load ? (4'b0001 << sel) : '0;
      // A capture of the bit being cleared re-sets it: the set wins.
      pending_d = (pending_q & ~clr) | req;
      drop_d    = |(req & pending_q & ~clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         drop_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
         last_q    <= '0;
`endif
      end else begin
         pending_q <= pending_d;
         drop_q    <= drop_d;
`ifdef ROUND_ROBIN_EN
         if (load) last_q <= sel;
`endif
         case (state_q)
            IDLE: begin
               if (load) begin
                  code_q  <= sel;
                  valid_q <= 1'b1;
                  state_q <= SHOW;
               end
            end
            SHOW: begin
               if (bus.READY) begin
                  if (load) begin
                     code_q <= sel;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.A0       = code_q[0];
   assign bus.A1       = code_q[1];
   assign bus.VALID    = valid_q;
   assign bus.DROP     = drop_q;
   assign bus.PEND_CNT = 3'(pending_q[0]) + 3'(pending_q[1]) + 3'(pending_q[2]) + 3'(pending_q[3]);
endmodule

// File: doc/encoder4to2_seq.md
# encoder4to2_seq

Sequential 4-to-2 request encoder: the inverse of the 2-to-4 decoder in the combinational library. It latches pulse requests on four one-hot lines and holds them as sticky pending bits. It then emits the index of one pending request at a time as a 2-bit code, using a valid/ready handshake. It sits between independent request sources and a downstream consumer that accepts one encoded index per transfer, for example a decoder-driven select path.

## Interface
- No parameters.
- clk     in   1  rising-edge clock
- rst_n   in   1  asynchronous active-low reset
- EN      in   1  capture enable; when 0, D0..D3 are ignored
- D0..D3  in   1 each  request strobes; level sampled every clock
- A0, A1  out  1 each  encoded index {A1,A0} of the presented request
- VALID   out  1  {A1,A0} holds a request
- READY   in   1  consumer accepts; a transfer occurs on a clock where VALID=1 and READY=1
- PEND_CNT out 3  number of pending (not yet presented) requests, 0..4
- DROP    out  1  one-cycle pulse: a captured request merged into a bit already pending

## Operation
- pending[3:0] register; reset 0.
- pending_next = (pending & ~clr) | (EN ? {D3,D2,D1,D0} : 0).
  - clr is the one-hot bit selected for loading this cycle.
  - A set and a clear of the same bit in one cycle: the set wins, and the request stays pending.
- DROP_next = EN & |({D3..D0} & pending & ~clr). DROP is registered; reset 0.
- State machine, reset state IDLE:
  - IDLE: if pending≠0, select index s, load {A1,A0}=s, set VALID=1, clear pending[s], and go to SHOW. Otherwise stay in IDLE.
  - SHOW: hold {A1,A0} and VALID stable while READY=0.
    - On READY=1 with pending≠0: load the next s in the same cycle (back-to-back) and stay in SHOW.
    - On READY=1 with pending=0: VALID=0 and go to IDLE.
- Selection uses the registered pending value only, never the live D inputs.
- Fixed priority: D3 > D2 > D1 > D0.
- PEND_CNT = popcount(pending), driven combinationally from the register.
- EN does not gate the output handshake. Pending requests drain with EN=0.
- Reset values: A0=0, A1=0, VALID=0, DROP=0, PEND_CNT=0, state IDLE. Under ROUND_ROBIN_EN, last=0.
- Reset asserted mid-transfer clears everything immediately. A presented but unaccepted request is lost.

## Timing
- Latency: a D pulse sampled at edge n sets pending after edge n. VALID and the code are valid after edge n+1, which is 2 cycles.
- Throughput: one transfer per clock while READY=1 and pending≠0.
- VALID is never deasserted while READY=0. {A1,A0} changes only on a transfer or on a load from IDLE.
- DROP is asserted for the cycle after the offending capture edge.
- All outputs are registered, except PEND_CNT, which is a combinational decode of a register.

## Configuration
- ROUND_ROBIN_EN defined: rotating priority.
  - A 2-bit register last holds the most recently loaded index; reset value 0.
  - The search order is last-1, last-2, last-3, last (mod 4), so the first search after reset is 3,2,1,0.
  - last updates on every load.
- ROUND_ROBIN_EN undefined: fixed priority D3 > D2 > D1 > D0, and no last register exists.

## Test plan
- Reset, then a single D2 pulse with EN=1 and READY=1: VALID=1 and {A1,A0}=10 two cycles after the pulse, for exactly one cycle. PEND_CNT goes 0→1→0.
- D0..D3 pulsed together, with READY held 0 for 5 cycles and then held 1:
  - VALID holds with {A1,A0}=11 while READY=0.
  - Then codes 10, 01, 00 on consecutive cycles, then VALID=0.
  - PEND_CNT reads 3, then 2, 1, 0.
- D1 pulsed twice while pending[1] is set: DROP=1 for one cycle. Only one transfer with code 01 occurs.
- EN=0 with D3 held high for 4 cycles: no VALID and PEND_CNT=0. Requests already pending still drain with EN=0.
- D3 held high continuously:
  - ROUND_ROBIN_EN undefined: D3 starves D0. Every transfer is 11 while D0 is pending.
  - ROUND_ROBIN_EN defined: D0 is granted within 2 transfers.
- rst_n pulsed low while VALID=1 and pending=0110: all outputs return to 0 asynchronously. No VALID follows after release.
